// File: rtl/roi_harness_pkg.sv
// roi_harness_pkg: shared FSM state type and counter-width helper for the ROI serial harness
package roi_harness_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CAPTURE, UNLOAD} state_e;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/serial_shr.sv
// serial_shr: left-shifting register with serial in, parallel load (load wins over shift)
module serial_shr #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ld,
  input  logic         si,
  input  logic [W-1:0] pd,
  output logic [W-1:0] q
);
  logic [W-1:0] shr_q, shr_d;
  // next contents: parallel load, else shift left taking si at the LSB
  always_comb shr_d = ld ? pd : en ? {shr_q[W-2:0], si} : shr_q;
  // register with synchronous clear
  always_ff @(posedge clk) shr_q <= rst ? '0 : shr_d;
  assign q = shr_q;
endmodule

// File: rtl/roi_serial_harness.sv
// roi_serial_harness: serial load / apply / settle / capture / serial unload around an external ROI; ROI_HARNESS_PARITY_EN appends an even-parity bit
module roi_serial_harness
  import roi_harness_pkg::*;
#(
  parameter int DIN_N      = 256,
  parameter int DOUT_N     = 256,
  parameter int SETTLE_CYC = 1,
  parameter int AUTO_APPLY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              di,
  input  logic              di_valid,
  input  logic              stb,
  output logic [DIN_N-1:0]  din,
  input  logic [DOUT_N-1:0] dout,
  output logic              do_bit,
  output logic              do_valid,
  input  logic              do_ready,
  output logic              busy
);
  localparam int IW = cnt_w(DIN_N);
  localparam int OW = cnt_w(DOUT_N);
  localparam logic [IW-1:0] IN_FULL  = IW'(DIN_N);
  localparam logic [IW-1:0] IN_LAST  = IW'(DIN_N - 1);
  localparam logic [OW-1:0] OUT_FULL = OW'(DOUT_N);
  state_e state_q, state_d;
  logic [IW-1:0] in_cnt_q, in_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [7:0] settle_q, settle_d;
  logic [DIN_N-1:0] din_q, din_d;
  logic do_valid_q, do_valid_d, busy_q, busy_d;
  logic in_en, take, out_shift, done;
  logic [DIN_N-1:0] din_shr;
  logic [DOUT_N-1:0] dout_shr;
  logic unused_lsbs;
`ifdef ROI_HARNESS_PARITY_EN
  logic par_q, par_d;
`endif
  // FSM next state, counters and registered outputs
  always_comb begin
    in_en = state_q == IDLE && di_valid;
    take = state_q == UNLOAD && do_ready;
    out_shift = take && out_cnt_q != '0;
`ifdef ROI_HARNESS_PARITY_EN
    done = take && out_cnt_q == '0;
    par_d = state_q == CAPTURE ? ^dout : par_q;
`else
    done = take && out_cnt_q == OW'(1);
`endif
    in_cnt_d = state_q == APPLY ? '0 : (in_en && in_cnt_q != IN_FULL) ? in_cnt_q + IW'(1) : in_cnt_q;
    out_cnt_d = state_q == CAPTURE ? OUT_FULL : out_shift ? out_cnt_q - OW'(1) : out_cnt_q;
    settle_d = state_q == APPLY ? 8'(SETTLE_CYC) : state_q == SETTLE ? settle_q - 8'd1 : settle_q;
    din_d = state_q == APPLY ? din_shr : din_q;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (stb || (AUTO_APPLY != 0 && in_en && in_cnt_q == IN_LAST)) ? APPLY : IDLE;
      APPLY:   state_d = SETTLE;
      SETTLE:  state_d = settle_q <= 8'd1 ? CAPTURE : SETTLE;
      CAPTURE: state_d = UNLOAD;
      UNLOAD:  state_d = done ? IDLE : UNLOAD;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    do_valid_d = state_d == UNLOAD;
  end
  // state and output registers, synchronous reset
  always_ff @(posedge clk) begin
    state_q    <= rst ? IDLE : state_d;
    in_cnt_q   <= rst ? '0 : in_cnt_d;
    out_cnt_q  <= rst ? '0 : out_cnt_d;
    settle_q   <= rst ? '0 : settle_d;
    din_q      <= rst ? '0 : din_d;
    do_valid_q <= rst ? 1'b0 : do_valid_d;
    busy_q     <= rst ? 1'b0 : busy_d;
  end
`ifdef ROI_HARNESS_PARITY_EN
  // parity of the captured word, presented after the data bits
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
  assign do_bit = do_valid_q & (out_cnt_q == '0 ? par_q : dout_shr[DOUT_N-1]);
`else
  assign do_bit = do_valid_q & dout_shr[DOUT_N-1];
`endif
  serial_shr #(.W(DIN_N)) u_in (
    .clk(clk), .rst(rst), .en(in_en), .ld(1'b0), .si(di), .pd('0), .q(din_shr)
  );
  serial_shr #(.W(DOUT_N)) u_out (
    .clk(clk), .rst(rst), .en(out_shift), .ld(state_q == CAPTURE), .si(1'b0), .pd(dout), .q(dout_shr)
  );
  assign unused_lsbs = ^dout_shr[DOUT_N-2:0];
  assign din = din_q;
  assign do_valid = do_valid_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_roi_serial_harness.sv
// tb_roi_serial_harness: randomized and directed checks of the harness against a word-level model
module tb_roi_serial_harness;
`ifdef ROI_HARNESS_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = 8 + PAR;
  logic clk = 0, rst = 1, di = 0, dv = 0, stb = 0, rdy = 1;
  logic [7:0] din, dout;
  logic dob, dov, busy;
  logic di2 = 0, dv2 = 0, stb2 = 0, rdy2 = 1;
  logic [7:0] din2, dout2;
  logic dob2, dov2, busy2;
  int errs = 0, checks = 0;
  assign dout = din;
  assign dout2 = din2;
  always #5 clk = ~clk;

  roi_serial_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(1), .AUTO_APPLY(0)) dut (
    .clk(clk), .rst(rst), .di(di), .di_valid(dv), .stb(stb), .din(din), .dout(dout),
    .do_bit(dob), .do_valid(dov), .do_ready(rdy), .busy(busy));
  roi_serial_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE_CYC(1), .AUTO_APPLY(1)) dut2 (
    .clk(clk), .rst(rst), .di(di2), .di_valid(dv2), .stb(stb2), .din(din2), .dout(dout2),
    .do_bit(dob2), .do_valid(dov2), .do_ready(rdy2), .busy(busy2));

  function automatic logic [15:0] stream_of(input logic [7:0] w);
    return PAR != 0 ? {7'd0, w, ^w} : {8'd0, w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_in(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      di = bits[i];
      dv = 1;
      tick();
    end
    dv = 0;
  endtask

  task automatic apply();
    stb = 1;
    tick();
    stb = 0;
  endtask

  // mode 0: always ready, 1: ready alternates 1,0,1,0 over unload cycles, 2: random ready
  task automatic collect(input int mode, output logic [15:0] got, output int cnt, output int lat, output int hold_err);
    int ph;
    logic prev_held, prev;
    got = 0; cnt = 0; lat = 0; hold_err = 0; ph = 0; prev_held = 0; prev = 0;
    for (int c = 0; c < 200; c++) begin
      if (!dov && cnt > 0) break;
      rdy = mode == 0 ? 1'b1 : mode == 1 ? ((ph % 2) == 0) : 1'($urandom_range(0, 1));
      if (dov) begin
        if (prev_held && dob !== prev) hold_err++;
        if (rdy) begin
          got = {got[14:0], dob};
          cnt++;
        end
        prev_held = !rdy;
        prev = dob;
        ph++;
      end else lat++;
      tick();
    end
    rdy = 1;
  endtask

  task automatic test_reset();
    rst = 1; stb = 1; dv = 1; di = 1;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dov !== 1'b0) begin errs++; $display("FAIL reset_do_valid got=%b exp=0", dov); end
    checks++; if (dob !== 1'b0) begin errs++; $display("FAIL reset_do got=%b exp=0", dob); end
    checks++; if (din !== 8'h00) begin errs++; $display("FAIL reset_din got=%h exp=00", din); end
    rst = 0; stb = 0; dv = 0; di = 0;
    tick();
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_stb_priority busy got=%b exp=0", busy); end
    checks++; if (dut.in_cnt_q !== 4'd0) begin errs++; $display("FAIL reset_in_cnt got=%0d exp=0", dut.in_cnt_q); end
  endtask

  task automatic test_basic();
    logic [15:0] got;
    int cnt, lat, he;
    shift_in(16'hA5, 8);
    apply();
    checks++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy got=%b exp=1", busy); end
    tick();
    checks++; if (din !== 8'hA5) begin errs++; $display("FAIL basic_din got=%h exp=a5", din); end
    collect(0, got, cnt, lat, he);
    checks++; if (lat !== 2) begin errs++; $display("FAIL basic_latency got=%0d exp=2", lat); end
    checks++; if (cnt !== NB) begin errs++; $display("FAIL basic_count got=%0d exp=%0d", cnt, NB); end
    checks++; if (got !== stream_of(8'hA5)) begin errs++; $display("FAIL basic_stream got=%h exp=%h", got, stream_of(8'hA5)); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end got=%b exp=0", busy); end
    checks++; if (dob !== 1'b0) begin errs++; $display("FAIL basic_do_idle got=%b exp=0", dob); end
  endtask

  task automatic test_overflow();
    logic [15:0] got;
    int cnt, lat, he;
    shift_in(16'b1100001111, 10);
    checks++; if (dut.in_cnt_q !== 4'd8) begin errs++; $display("FAIL ovf_in_cnt got=%0d exp=8", dut.in_cnt_q); end
    apply();
    tick();
    checks++; if (din !== 8'h0F) begin errs++; $display("FAIL ovf_din got=%h exp=0f", din); end
    collect(0, got, cnt, lat, he);
    checks++; if (got !== stream_of(8'h0F)) begin errs++; $display("FAIL ovf_stream got=%h exp=%h", got, stream_of(8'h0F)); end
  endtask

  task automatic test_backpressure();
    logic [15:0] got;
    int cnt, lat, he;
    shift_in(16'hA7, 8);
    apply();
    tick();
    collect(1, got, cnt, lat, he);
    checks++; if (cnt !== NB) begin errs++; $display("FAIL bp_count got=%0d exp=%0d", cnt, NB); end
    checks++; if (got !== stream_of(8'hA7)) begin errs++; $display("FAIL bp_stream got=%h exp=%h", got, stream_of(8'hA7)); end
    checks++; if (he !== 0) begin errs++; $display("FAIL bp_hold got=%0d exp=0", he); end
  endtask

  task automatic test_abort();
    logic [15:0] got;
    int cnt, lat, he;
    shift_in(16'hC3, 8);
    apply();
    for (int c = 0; c < 20 && !dov; c++) tick();
    for (int k = 0; k < 3; k++) tick();
    checks++; if (dov !== 1'b1 || dob !== 1'b0) begin errs++; $display("FAIL abort_4th_bit got=%b/%b exp=1/0", dov, dob); end
    rst = 1;
    tick();
    rst = 0;
    checks++; if (dov !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL abort_idle got=%b/%b exp=0/0", dov, busy); end
    shift_in(16'h81, 8);
    apply();
    tick();
    checks++; if (din !== 8'h81) begin errs++; $display("FAIL abort_din got=%h exp=81", din); end
    collect(0, got, cnt, lat, he);
    checks++; if (got !== stream_of(8'h81)) begin errs++; $display("FAIL abort_stream got=%h exp=%h", got, stream_of(8'h81)); end
  endtask

  task automatic test_auto_apply();
    logic [7:0] w;
    logic [15:0] got;
    int cnt;
    w = 8'h3C; got = 0; cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      di2 = w[i];
      dv2 = 1;
      if (i == 0) begin
        checks++; if (busy2 !== 1'b0) begin errs++; $display("FAIL auto_early got=%b exp=0", busy2); end
      end
      tick();
    end
    dv2 = 0;
    checks++; if (busy2 !== 1'b1) begin errs++; $display("FAIL auto_apply got=%b exp=1", busy2); end
    tick();
    checks++; if (din2 !== 8'h3C) begin errs++; $display("FAIL auto_din got=%h exp=3c", din2); end
    for (int c = 0; c < 50; c++) begin
      if (!dov2 && cnt > 0) break;
      if (dov2) begin
        got = {got[14:0], dob2};
        cnt++;
      end
      tick();
    end
    checks++; if (got !== stream_of(8'h3C) || cnt !== NB) begin errs++; $display("FAIL auto_stream got=%h/%0d exp=%h/%0d", got, cnt, stream_of(8'h3C), NB); end
  endtask

  task automatic test_random();
    logic [15:0] bits, got;
    logic [7:0] w;
    int n, cnt, lat, he;
    logic late;
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(8, 12);
      bits = 16'($urandom);
      late = 1'($urandom_range(0, 1));
      w = 0;
      for (int i = n - 1; i >= 0; i--) w = 8'((int'(w) * 2 + int'(bits[i])) % 256);
      for (int i = n - 1; i >= 0; i--) begin
        while ($urandom_range(0, 3) == 0) begin
          dv = 0;
          tick();
        end
        di = bits[i];
        dv = 1;
        stb = late && i == 0;
        tick();
      end
      dv = 0;
      if (late) stb = 0;
      else apply();
      tick();
      checks++; if (din !== w) begin errs++; $display("FAIL rand_din it=%0d got=%h exp=%h", it, din, w); end
      collect(2, got, cnt, lat, he);
      checks++; if (got !== stream_of(w) || cnt !== NB) begin errs++; $display("FAIL rand_stream it=%0d got=%h/%0d exp=%h/%0d", it, got, cnt, stream_of(w), NB); end
      checks++; if (he !== 0) begin errs++; $display("FAIL rand_hold it=%0d got=%0d exp=0", it, he); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_abort();
    test_auto_apply();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule

// File: doc/roi_serial_harness.md
ROI_SERIAL_HARNESS -- requirements
Module: roi_serial_harness

Interface
REQ-001 Parameter DIN_N, default 256: width of the parallel stimulus word driven to the ROI; minimum 2.
REQ-002 Parameter DOUT_N, default 256: width of the parallel response word captured from the ROI; minimum 2.
REQ-003 Parameter SETTLE_CYC, default 1: cycles between driving din and capturing dout; range 1..255.
REQ-004 Parameter AUTO_APPLY, default 0: 1 = apply automatically when DIN_N bits have been accepted; 0 = apply only on stb.
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 di  input  1  serial stimulus bit, MSB of the word first.
REQ-008 di_valid  input  1  di is accepted this cycle.
REQ-009 stb  input  1  apply request.
REQ-010 din  output  DIN_N  registered stimulus word to the ROI.
REQ-011 dout  input  DOUT_N  response word from the ROI.
REQ-012 do  output  1  serial response bit, MSB first.
REQ-013 do_valid  output  1  do holds a valid bit.
REQ-014 do_ready  input  1  consumer takes do this cycle.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, APPLY, SETTLE, CAPTURE, UNLOAD. Each state lasts exactly the cycles stated here.
REQ-017 IDLE: on di_valid, din_shr <= {din_shr[DIN_N-2:0], di}; in_cnt increments, saturating at DIN_N.
REQ-018 IDLE: move to APPLY when stb=1, or when AUTO_APPLY=1 and in_cnt reaches DIN_N in that cycle.
REQ-019 di_valid with stb in the same IDLE cycle: the bit is shifted in and is part of the applied word.
REQ-020 Manual mode, more than DIN_N bits: shifting continues, oldest bits are discarded, and in_cnt stays at DIN_N.
REQ-021 APPLY, one cycle: din <= din_shr and in_cnt <= 0; din_shr is retained.
REQ-022 SETTLE: lasts exactly SETTLE_CYC cycles, counted by a down-counter, then CAPTURE.
REQ-023 CAPTURE, one cycle: dout_shr <= dout and out_cnt <= DOUT_N.
REQ-024 UNLOAD: do_valid=1 and do=dout_shr[DOUT_N-1].
REQ-025 UNLOAD, do_ready=1: dout_shr shifts left with zero fill and out_cnt decrements; do_ready=0 holds do stable.
REQ-026 UNLOAD, last data bit taken: return to IDLE, unless parity is compiled in (REQ-033).
REQ-027 Latency: stb in cycle t gives APPLY at t+1, din visible at t+2, CAPTURE at t+2+SETTLE_CYC, first do_valid at t+3+SETTLE_CYC.
REQ-028 Outside IDLE: di, di_valid and stb are ignored; din_shr and in_cnt do not change.
REQ-029 din holds its value until the next APPLY; do=0 whenever do_valid=0.

Reset
REQ-030 When rst=1 at a clock edge, the following are set: state IDLE; din, din_shr and dout_shr zero; in_cnt, out_cnt and the settle counter zero; do=0, do_valid=0, busy=0.
REQ-031 Reset in any state, including mid-UNLOAD, aborts the transfer; the next cycle starts in IDLE with no residual output bits.
REQ-032 rst has priority over stb, di_valid and do_ready in the same cycle.

Configuration
REQ-033 Macro ROI_HARNESS_PARITY_EN defined: after the last data bit, UNLOAD presents one extra bit with do_valid=1, do = XOR of the captured word; this bit is consumed on do_ready, then IDLE.
REQ-034 Macro undefined: exactly DOUT_N bits are unloaded per transfer and no parity logic exists.

Structure
REQ-035 Package roi_harness_pkg holds the FSM state enum typedef and the counter-width helper function ($clog2-based).
REQ-036 Sub-module serial_shr (parametrised width, shift-enable, parallel load, serial in/out) is instantiated twice: once for input, once for output.
REQ-037 The ROI is instantiated outside this block.

Verification
Common bench setup: DIN_N=DOUT_N=8, SETTLE_CYC=1, ROI modelled as dout=din, do_ready=1 unless stated.
REQ-038 Shift 8'hA5, then stb -> din=8'hA5 at t+2; do stream 1,0,1,0,0,1,0,1 starting t+4; busy low after the eighth bit.
REQ-039 AUTO_APPLY=1, shift 8'h3C, no stb -> APPLY in the cycle after the eighth di_valid; output 8'h3C.
REQ-040 Shift 10 bits 1,1,0,0,0,0,1,1,1,1, then stb -> din=8'h0F; in_cnt held at 8.
REQ-041 Toggle do_ready 1,0,1,0 during UNLOAD -> each bit is held while do_ready=0; 8 bits, no loss or duplication.
REQ-042 Assert rst at the 4th unloaded bit -> do_valid=0 and busy=0 next cycle; a following transfer of 8'h81 returns 8'h81.
REQ-043 ROI_HARNESS_PARITY_EN defined, word 8'hA7 -> 8 data bits, then a parity bit of 1; 8'hA5 gives a parity bit of 0.
